digit_seq_ctrl: RTL and testbench

DIGIT_SEQ_CTRL -- requirements
Module: digit_seq_ctrl

---
 rtl/digit_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_digit_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_seq_ctrl.sv
// digit_seq_ctrl: ASCII digits -> concatenator strobes; result sent back as 4 UART bytes. Strobe 1 cycle after rx_done, first tx byte 1 cycle after dig_done.
// rx_done only honoured in IDLE (dropped otherwise); each tx byte waits for tx_done. Optional byte echo: CTRL_ECHO_EN.
module digit_seq_ctrl #(
    parameter int         HOLD_CYC     = 2,
    parameter int         MAX_DIGITS   = 9,
    parameter logic [7:0] TERM_CHAR    = 8'h0D,
    parameter int         DONE_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  dig_dato,
    output logic        dig_num_ready,
    output logic        dig_fin,
    input  logic [31:0] dig_resultado,
    input  logic        dig_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic        err
);
    localparam int            TW        = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [3:0]    MAX_CNT   = 4'(MAX_DIGITS);
    localparam logic [3:0]    HOLD_LAST = 4'(HOLD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DONE_TIMEOUT - 1);

`ifdef CTRL_ECHO_EN
    typedef enum logic [2:0] {IDLE, PULSE, GAP, FIN, TXB, TXW, ECHO, ECHOW} state_t;
`else
    typedef enum logic [2:0] {IDLE, PULSE, GAP, FIN, TXB, TXW} state_t;
`endif

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    hold_cnt, hold_n;
    logic [1:0]    idx, idx_n;
    logic [31:0]   res, res_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [7:0]    dato_q, dato_n;
    logic          err_q, err_n;
    logic          act_vld;
    logic [7:0]    act_byte;
    logic          is_digit;
`ifdef CTRL_ECHO_EN
    logic [7:0]    echo_q, echo_n;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_cnt <= '0;
            idx      <= '0;
            res      <= '0;
            tmo_cnt  <= '0;
            dato_q   <= '0;
            err_q    <= 1'b0;
`ifdef CTRL_ECHO_EN
            echo_q   <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hold_cnt <= hold_n;
            idx      <= idx_n;
            res      <= res_n;
            tmo_cnt  <= tmo_n;
            dato_q   <= dato_n;
            err_q    <= err_n;
`ifdef CTRL_ECHO_EN
            echo_q   <= echo_n;
`endif
        end
    end

    // With echo enabled the byte is acted on only once its echo has been sent.
`ifdef CTRL_ECHO_EN
    assign act_vld  = (state == ECHOW) && tx_done;
    assign act_byte = echo_q;
`else
    assign act_vld  = (state == IDLE) && rx_done;
    assign act_byte = rx_data;
`endif
    assign is_digit = (act_byte >= 8'h30) && (act_byte <= 8'h39);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold_cnt;
        idx_n   = idx;
        res_n   = res;
        tmo_n   = tmo_cnt;
        dato_n  = dato_q;
        err_n   = err_q;
`ifdef CTRL_ECHO_EN
        echo_n  = echo_q;
`endif
        case (state)
            IDLE: begin
`ifdef CTRL_ECHO_EN
                if (rx_done) begin
                    echo_n  = rx_data;
                    state_n = ECHO;
                end
`endif
            end
            PULSE: begin
                if (hold_cnt == HOLD_LAST) state_n = GAP;
                else                       hold_n  = hold_cnt + 4'd1;
            end
            GAP: state_n = IDLE;
            FIN: begin
                if (dig_done) begin
                    res_n   = dig_resultado;
                    idx_n   = '0;
                    state_n = TXB;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmo_n   = tmo_cnt + 1'b1;
                end
            end
            TXB: state_n = TXW;
            TXW: begin
                if (tx_done) begin
                    if (idx == 2'd3) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = TXB;
                    end
                end
            end
`ifdef CTRL_ECHO_EN
            ECHO:  state_n = ECHOW;
            ECHOW: begin
            end
`endif
            default: state_n = IDLE;
        endcase

        if (act_vld) begin
            state_n = IDLE;
            if (is_digit) begin
                if (cnt < MAX_CNT) begin
                    dato_n  = act_byte - 8'h30;
                    cnt_n   = cnt + 4'd1;
                    hold_n  = '0;
                    state_n = PULSE;
                    if (cnt == 4'd0) err_n = 1'b0;
                end else begin
                    err_n = 1'b1;
                end
            end else if ((act_byte == TERM_CHAR) && (cnt != 4'd0)) begin
                tmo_n   = '0;
                state_n = FIN;
            end
        end
    end

    always_comb begin
        tx_data = '0;
        if ((state == TXB) || (state == TXW)) begin
            case (idx)
                2'd0:    tx_data = res[31:24];
                2'd1:    tx_data = res[23:16];
                2'd2:    tx_data = res[15:8];
                default: tx_data = res[7:0];
            endcase
        end
`ifdef CTRL_ECHO_EN
        if ((state == ECHO) || (state == ECHOW)) tx_data = echo_q;
`endif
    end

`ifdef CTRL_ECHO_EN
    assign tx_start = (state == TXB) || (state == ECHO);
`else
    assign tx_start = (state == TXB);
`endif
    assign dig_num_ready = (state == PULSE);
    assign dig_fin       = (state == FIN);
    assign busy          = (state != IDLE);
    assign dig_dato      = dato_q;
    assign err           = err_q;

endmodule

// File: tb/tb_digit_seq_ctrl.sv
// Scoreboard bench for digit_seq_ctrl: expected digits and tx bytes are queued at stimulus time and popped by output monitors.
module tb_digit_seq_ctrl;
    localparam int HOLD = 2;
`ifdef CTRL_ECHO_EN
    localparam bit ECHO_ON = 1'b1;
`else
    localparam bit ECHO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic [7:0]  dig_dato;
    logic        dig_num_ready;
    logic        dig_fin;
    logic [31:0] dig_resultado = '0;
    logic        dig_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    int nr_cnt = 0;
    int tx_cnt = 0;
    int hold_at = -1;
    logic [7:0] nr_q[$];
    logic [7:0] tx_q[$];

    digit_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_done(rx_done),
        .dig_dato(dig_dato), .dig_num_ready(dig_num_ready), .dig_fin(dig_fin),
        .dig_resultado(dig_resultado), .dig_done(dig_done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Digit strobe monitor: length, stability through PULSE and GAP, value.
    initial begin : nr_mon
        logic [7:0] d;
        int         len;
        bit         stab;
        forever begin
            @(negedge clk);
            if (reset && dig_num_ready) begin
                d = dig_dato; len = 0; stab = 1'b1;
                while (dig_num_ready && len < 40) begin
                    len++;
                    if (dig_dato !== d) stab = 1'b0;
                    @(negedge clk);
                end
                nr_cnt++;
                chk("nr_len", 32'(len), 32'(HOLD));
                chk("nr_stable", 32'(stab), 32'd1);
                chk("nr_gap_dato", 32'(dig_dato), 32'(d));
                if (nr_q.size() == 0) chk("nr_unexpected", 32'd1, 32'd0);
                else chk("nr_dato", 32'(d), 32'(nr_q.pop_front()));
            end
        end
    end

    // Transmitter model: checks each tx_start byte, then answers with tx_done.
    initial begin : tx_mon
        logic [7:0] b;
        bit         resp;
        forever begin
            @(negedge clk);
            if (reset && tx_start) begin
                b = tx_data;
                tx_cnt++;
                resp = (tx_cnt != hold_at);
                if (tx_q.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else chk("tx_data", 32'(b), 32'(tx_q.pop_front()));
                @(negedge clk);
                chk("tx_start_width", 32'(tx_start), 32'd0);
                if (resp) begin
                    repeat (2) @(negedge clk);
                    chk("tx_hold", 32'(tx_data), 32'(b));
                    @(posedge clk); #1 tx_done = 1'b1;
                    @(posedge clk); #1 tx_done = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit echoed);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        if (ECHO_ON && echoed) tx_q.push_back(b);
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_fin(input string tag);
        @(negedge clk);
        for (int i = 0; i < 100 && !dig_fin; i++) @(negedge clk);
        chk(tag, 32'(dig_fin), 32'd1);
    endtask

    task automatic do_done(input logic [31:0] v);
        for (int k = 3; k >= 0; k--) tx_q.push_back(v[8*k +: 8]);
        @(posedge clk); #1;
        chk("fin_hold", 32'(dig_fin), 32'd1);
        dig_resultado = v;
        dig_done = 1'b1;
        @(posedge clk); #1;
        dig_done = 1'b0;
        dig_resultado = '0;
        chk("fin_drop", 32'(dig_fin), 32'd0);
    endtask

    function automatic logic [31:0] outs();
        return 32'({dig_dato, dig_num_ready, dig_fin, tx_data, tx_start, busy, err});
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        int n;
        bit seen;
        logic [31:0] v;

        repeat (3) @(posedge clk);
        #1 chk("reset_outs", outs(), 32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", outs(), 32'd0);

        // '1' (with a byte dropped during PULSE), '2', '3' back-to-back, CR, result 123
        base = nr_cnt;
        nr_q.push_back(8'd1);
        send(8'h31, 1);
        send(8'h38, 0);
        wait_idle("t37_idle1");
        nr_q.push_back(8'd2);
        send(8'h32, 1);
        for (int i = 0; i < 50 && !dig_num_ready; i++) @(negedge clk);
        for (int i = 0; i < 50 && dig_num_ready; i++) @(negedge clk);
        nr_q.push_back(8'd3);
        send(8'h33, 1);
        wait_idle("t37_idle3");
        send(8'h0D, 1);
        wait_fin("t37_fin");
        do_done(32'd123);
        wait_idle("t37_idle_tx");
        chk("t37_pulses", 32'(nr_cnt - base), 32'd3);
        chk("t37_err", 32'(err), 32'd0);

        // ten '7': ninth accepted, tenth dropped with err
        base = nr_cnt;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) nr_q.push_back(8'd7);
            send(8'h37, 1);
            wait_idle("t38_idle");
            if (i == 8) chk("t38_err_9th", 32'(err), 32'd0);
            if (i == 9) chk("t38_err_10th", 32'(err), 32'd1);
        end
        send(8'h0D, 1);
        wait_fin("t38_fin");
        v = $urandom;
        do_done(v);
        wait_idle("t38_idle_tx");
        chk("t38_pulses", 32'(nr_cnt - base), 32'd9);
        chk("t38_err_sticky", 32'(err), 32'd1);

        // CR with no digits, a letter, and a stray dig_done: no activity
        base = nr_cnt;
        send(8'h0D, 1);
`ifdef CTRL_ECHO_EN
        wait_idle("t39_idle_a");
`else
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= busy | dig_fin | dig_num_ready; end
        chk("t39_quiet_cr", 32'(seen), 32'd0);
`endif
        send(8'h41, 1);
`ifdef CTRL_ECHO_EN
        wait_idle("t39_idle_b");
`else
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= busy | dig_fin | dig_num_ready; end
        chk("t39_quiet_a", 32'(seen), 32'd0);
`endif
        @(posedge clk); #1 dig_done = 1'b1; dig_resultado = 32'h1234_5678;
        @(posedge clk); #1 dig_done = 1'b0; dig_resultado = '0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); seen |= busy | tx_start; end
        chk("t39_stray_done", 32'(seen), 32'd0);
        chk("t39_pulses", 32'(nr_cnt - base), 32'd0);

        // '5', CR, no dig_done: timeout
        nr_q.push_back(8'd5);
        send(8'h35, 1);
        wait_idle("t40_idle");
        chk("t40_err_cleared", 32'(err), 32'd0);
        send(8'h0D, 1);
        wait_fin("t40_fin");
        n = 0;
        while (dig_fin && n < 1100) begin n++; @(negedge clk); end
        chk("t40_tmo_len", 32'(n), 32'd1023);
        chk("t40_after", 32'({err, dig_fin, busy}), 32'b100);
        nr_q.push_back(8'd4);
        send(8'h34, 1);
        wait_idle("t40_idle4");
        chk("t40_err_new", 32'(err), 32'd0);

        // reset while waiting for tx_done of the second result byte
        send(8'h0D, 1);
        wait_fin("t41_fin");
        hold_at = tx_cnt + 2;
        do_done(32'hA1B2_C3D4);
        for (int i = 0; i < 100 && tx_cnt < hold_at; i++) @(negedge clk);
        chk("t41_reach", 32'(tx_cnt), 32'(hold_at));
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("t41_async_outs", outs(), 32'd0);
        tx_q.delete();
        hold_at = -1;
        base = tx_cnt;
        n = nr_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= tx_start | dig_fin | dig_num_ready | busy; end
        chk("t41_quiet", 32'(seen), 32'd0);
        chk("t41_no_tx", 32'(tx_cnt - base), 32'd0);
        chk("t41_no_nr", 32'(nr_cnt - n), 32'd0);
        nr_q.push_back(8'd6);
        send(8'h36, 1);
        wait_idle("t41_idle6");
        chk("t41_recover", 32'(nr_cnt - n), 32'd1);

`ifdef CTRL_ECHO_EN
        base = nr_cnt;
        n = tx_cnt;
        nr_q.push_back(8'd9);
        send(8'h39, 1);
        wait_idle("t42_idle");
        chk("t42_echo", 32'(tx_cnt - n), 32'd1);
        chk("t42_pulse", 32'(nr_cnt - base), 32'd1);
`endif

        repeat (5) @(negedge clk);
        chk("queues_empty", 32'(nr_q.size() + tx_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
